gowin_sp_req_adapter: RTL and testbench

Request/response front-end for one Gowin SP block RAM configured as 512 x 32 bit. It converts a valid/ready memory request stream (read or byte-masked write) into SP primitive controls. Read data returns on a valid/ready response stream, buffered so that response backpressure never loses data. It sits directly upstream of the SP instance in every BGPU memory built from single-port BSRAM, and drives all SP inputs.

---
 rtl/gowin_sp_req_adapter.sv | 125 ++++++++++++
 tb/tb_gowin_sp_req_adapter.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gowin_sp_req_adapter.sv
// Request/response front-end for one Gowin SP block RAM (512 x 32).
// Turns a valid/ready read/write stream into SP controls and returns read data
// through a small credit-protected response FIFO.
module gowin_sp_req_adapter #(
  parameter int unsigned OutReg = 0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [8:0]  req_addr_i,
  input  logic [3:0]  req_be_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        sp_clk_o,
  output logic        sp_ce_o,
  output logic        sp_oce_o,
  output logic        sp_wre_o,
  output logic        sp_reset_o,
  output logic [2:0]  sp_blksel_o,
  output logic [13:0] sp_ad_o,
  output logic [31:0] sp_di_o,
  input  logic [31:0] sp_do_i
);

  localparam int unsigned Latency = 1 + OutReg;
  localparam int unsigned Depth   = Latency + 2;
  localparam int unsigned CntW    = $clog2(Depth + 1);
  localparam logic [CntW:0] DepthL = (CntW + 1)'(Depth);

  logic                req_fire;
  logic                rd_fire;
  logic                push;
  logic                pop;
  logic [3:0]          be_eff;
  logic [Latency-1:0]  rd_pipe_q, rd_pipe_d;
  logic [31:0]         fifo_q [Depth];
  logic [31:0]         fifo_d [Depth];
  logic [CntW-1:0]     fifo_count_q, fifo_count_d;
  logic [CntW-1:0]     wr_idx;
  logic [CntW:0]       used_d;
  logic                ready_q, ready_d;

  // Ready is a register so it carries no input-to-output path and reads 0 in reset.
  assign req_ready_o = ready_q;
  assign req_fire    = req_valid_i & ready_q;
  assign rd_fire     = req_fire & ~req_we_i;
  assign push        = rd_pipe_q[Latency-1];
  assign rsp_valid_o = (fifo_count_q != '0);
  assign pop         = rsp_valid_o & rsp_ready_i;
  assign rsp_rdata_o = fifo_q[0];

  assign sp_clk_o    = clk_i;
  assign sp_oce_o    = 1'b1;
  assign sp_reset_o  = ~rst_ni;
  assign sp_blksel_o = 3'b000;
  assign sp_di_o     = req_wdata_i;

  // SP controls straight from the request; an all-zero byte mask leaves CE low.
  always_comb begin
    be_eff   = req_we_i ? req_be_i : 4'hF;
    sp_ad_o  = {req_addr_i, 1'b0, be_eff};
    sp_ce_o  = req_fire & (|be_eff);
    sp_wre_o = req_fire & req_we_i;
  end

  // In-flight read tracker: one bit per SP read-pipeline stage.
  always_comb begin
    rd_pipe_d    = '0;
    rd_pipe_d[0] = rd_fire;
    for (int unsigned i = 1; i < Latency; i++) begin
      rd_pipe_d[i] = rd_pipe_q[i-1];
    end
  end

  // Shift-style FIFO: head always sits in entry 0; simultaneous pop and push keep order.
  always_comb begin
    fifo_d = fifo_q;
    wr_idx = pop ? (fifo_count_q - 1'b1) : fifo_count_q;
    if (pop) begin
      for (int unsigned i = 0; i + 1 < Depth; i++) begin
        fifo_d[i] = fifo_q[i+1];
      end
    end
    if (push) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        if (CntW'(i) == wr_idx) fifo_d[i] = sp_do_i;
      end
    end
    fifo_count_d = fifo_count_q + CntW'(push) - CntW'(pop);
  end

  // Credits: reads in the pipe plus buffered responses must stay below the FIFO size.
  always_comb begin
    used_d = {1'b0, fifo_count_d};
    for (int unsigned i = 0; i < Latency; i++) begin
      used_d = used_d + (CntW + 1)'(rd_pipe_d[i]);
    end
    ready_d = (used_d < DepthL);
  end

  // State registers; reset drops everything in flight or buffered.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_pipe_q    <= '0;
      fifo_count_q <= '0;
      ready_q      <= 1'b0;
      for (int unsigned i = 0; i < Depth; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      rd_pipe_q    <= rd_pipe_d;
      fifo_count_q <= fifo_count_d;
      ready_q      <= ready_d;
      fifo_q       <= fifo_d;
    end
  end

  fifo_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (push && !pop) |-> ({1'b0, fifo_count_q} < DepthL));

endmodule

// File: tb/tb_gowin_sp_req_adapter.sv
// Bench for gowin_sp_req_adapter: one instance per OutReg setting, each with a
// behavioural SP model, a reference memory and an in-order response scoreboard.
module tb_gowin_sp_req_adapter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [8:0]  req_addr  [2];
  logic [3:0]  req_be    [2];
  logic [31:0] req_wdata [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        sp_clk    [2];
  logic        sp_ce     [2];
  logic        sp_oce    [2];
  logic        sp_wre    [2];
  logic        sp_reset  [2];
  logic [2:0]  sp_blksel [2];
  logic [13:0] sp_ad     [2];
  logic [31:0] sp_di     [2];
  logic [31:0] sp_do     [2];

  gowin_sp_req_adapter #(.OutReg(0)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]), .req_we_i(req_we[0]),
    .req_addr_i(req_addr[0]), .req_be_i(req_be[0]), .req_wdata_i(req_wdata[0]),
    .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready[0]), .rsp_rdata_o(rsp_rdata[0]),
    .sp_clk_o(sp_clk[0]), .sp_ce_o(sp_ce[0]), .sp_oce_o(sp_oce[0]), .sp_wre_o(sp_wre[0]),
    .sp_reset_o(sp_reset[0]), .sp_blksel_o(sp_blksel[0]), .sp_ad_o(sp_ad[0]),
    .sp_di_o(sp_di[0]), .sp_do_i(sp_do[0])
  );

  gowin_sp_req_adapter #(.OutReg(1)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]), .req_we_i(req_we[1]),
    .req_addr_i(req_addr[1]), .req_be_i(req_be[1]), .req_wdata_i(req_wdata[1]),
    .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready[1]), .rsp_rdata_o(rsp_rdata[1]),
    .sp_clk_o(sp_clk[1]), .sp_ce_o(sp_ce[1]), .sp_oce_o(sp_oce[1]), .sp_wre_o(sp_wre[1]),
    .sp_reset_o(sp_reset[1]), .sp_blksel_o(sp_blksel[1]), .sp_ad_o(sp_ad[1]),
    .sp_di_o(sp_di[1]), .sp_do_i(sp_do[1])
  );

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = be[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    return r;
  endfunction

  // SP models: instance 0 without output register, instance 1 with it.
  logic [31:0] mem0 [512];
  logic [31:0] mem1 [512];
  logic [31:0] rd0, rd1a, rd1b;

  always @(posedge clk) begin
    if (sp_ce[0] && sp_wre[0])
      mem0[sp_ad[0][13:5]] <= merge(mem0[sp_ad[0][13:5]], sp_di[0], sp_ad[0][3:0]);
    if (sp_reset[0]) rd0 <= '0;
    else if (sp_ce[0] && !sp_wre[0]) rd0 <= mem0[sp_ad[0][13:5]];
  end

  always @(posedge clk) begin
    if (sp_ce[1] && sp_wre[1])
      mem1[sp_ad[1][13:5]] <= merge(mem1[sp_ad[1][13:5]], sp_di[1], sp_ad[1][3:0]);
    if (sp_reset[1]) begin
      rd1a <= '0;
      rd1b <= '0;
    end else begin
      if (sp_ce[1] && !sp_wre[1]) rd1a <= mem1[sp_ad[1][13:5]];
      if (sp_oce[1]) rd1b <= rd1a;
    end
  end

  assign sp_do[0] = rd0;
  assign sp_do[1] = rd1b;

  // Scoreboard
  typedef struct packed {
    logic [31:0] data;
    logic [31:0] cyc;
  } exp_t;

  exp_t        exp0 [$];
  exp_t        exp1 [$];
  logic [31:0] ref_mem [2][512];
  bit          strict [2];
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic sb_push(input int k, input logic [31:0] d);
    exp_t e;
    e.data = d;
    e.cyc  = cyc;
    if (k == 0) exp0.push_back(e);
    else exp1.push_back(e);
  endtask

  function automatic int qsize(input int k);
    return (k == 0) ? exp0.size() : exp1.size();
  endfunction

  // Response monitors: a pop happens at the edge following a negedge with valid & ready.
  always @(negedge clk) begin
    if (rst_n && rsp_valid[0] && rsp_ready[0]) begin
      if (exp0.size() == 0) check("spurious_rsp0", 32'(rsp_valid[0]), 32'd0);
      else begin
        check("rsp_data0", rsp_rdata[0], exp0[0].data);
        if (strict[0]) check("rsp_lat0", cyc, exp0[0].cyc + 2);
        void'(exp0.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && rsp_valid[1] && rsp_ready[1]) begin
      if (exp1.size() == 0) check("spurious_rsp1", 32'(rsp_valid[1]), 32'd0);
      else begin
        check("rsp_data1", rsp_rdata[1], exp1[0].data);
        if (strict[1]) check("rsp_lat1", cyc, exp1[0].cyc + 3);
        void'(exp1.pop_front());
      end
    end
  end

  task automatic do_req(input int k, input bit we, input logic [8:0] addr,
                        input logic [3:0] be, input logic [31:0] data);
    bit fired = 1'b0;
    req_valid[k] = 1'b1;
    req_we[k]    = we;
    req_addr[k]  = addr;
    req_be[k]    = be;
    req_wdata[k] = data;
    for (int i = 0; i < 40 && !fired; i++) begin
      @(negedge clk);
      if (req_ready[k]) begin
        fired = 1'b1;
        check("sp_ce", 32'(sp_ce[k]), (we && be == 4'h0) ? 32'd0 : 32'd1);
        check("sp_wre", 32'(sp_wre[k]), 32'(we));
        check("sp_ad", 32'(sp_ad[k]), 32'({addr, 1'b0, (we ? be : 4'hF)}));
        check("sp_di", sp_di[k], data);
        if (we) ref_mem[k][addr] = merge(ref_mem[k][addr], data, be);
        else sb_push(k, ref_mem[k][addr]);
      end
      @(posedge clk);
      #1;
    end
    req_valid[k] = 1'b0;
    check("req_accept", 32'(fired), 32'd1);
  endtask

  // Hold a read request for ncyc cycles, advancing the address after every fire.
  task automatic stream_reads(input int k, input logic [8:0] base, input int ncyc,
                              output int nfire);
    nfire        = 0;
    req_valid[k] = 1'b1;
    req_we[k]    = 1'b0;
    req_be[k]    = 4'h0;
    req_wdata[k] = '0;
    req_addr[k]  = base;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (req_ready[k]) begin
        nfire++;
        check("rd_ad", 32'(sp_ad[k]), 32'({req_addr[k], 1'b0, 4'hF}));
        sb_push(k, ref_mem[k][req_addr[k]]);
      end
      @(posedge clk);
      #1;
      req_addr[k] = base + 9'(nfire);
    end
    req_valid[k] = 1'b0;
  endtask

  task automatic hold_write(input int k, input logic [8:0] addr, input int ncyc,
                            output int nfire);
    nfire        = 0;
    req_valid[k] = 1'b1;
    req_we[k]    = 1'b1;
    req_be[k]    = 4'hF;
    req_addr[k]  = addr;
    req_wdata[k] = 32'h0BAD_F00D;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (req_ready[k]) begin
        nfire++;
        ref_mem[k][addr] = 32'h0BAD_F00D;
      end
      @(posedge clk);
      #1;
    end
    req_valid[k] = 1'b0;
  endtask

  task automatic wait_drain(input int k);
    for (int i = 0; i < 40 && qsize(k) != 0; i++) @(negedge clk);
    check("drain", 32'(qsize(k)), 32'd0);
    @(posedge clk);
    #1;
  endtask

  int n;

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 1'b0;
      req_we[k]    = 1'b0;
      req_addr[k]  = '0;
      req_be[k]    = '0;
      req_wdata[k] = '0;
      rsp_ready[k] = 1'b1;
      strict[k]    = 1'b0;
      for (int a = 0; a < 512; a++) ref_mem[k][a] = '0;
    end

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("rst_ready", 32'(req_ready[k]), 32'd0);
      check("rst_valid", 32'(rsp_valid[k]), 32'd0);
      check("rst_rdata", rsp_rdata[k], 32'd0);
      check("rst_ce", 32'(sp_ce[k]), 32'd0);
      check("rst_wre", 32'(sp_wre[k]), 32'd0);
      check("rst_sp_reset", 32'(sp_reset[k]), 32'd1);
      check("oce", 32'(sp_oce[k]), 32'd1);
      check("blksel", 32'(sp_blksel[k]), 32'd0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("ready_after_rst", 32'(req_ready[k]), 32'd1);
      check("sp_reset_rel", 32'(sp_reset[k]), 32'd0);
    end
    @(posedge clk);
    #1;

    // Preload addresses 0..15 in both memories
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 16; i++)
        do_req(k, 1'b1, 9'(i), 4'hF, 32'h1000_0000 * (k + 1) + 32'h0101_0101 * i);

    // Write then read back-to-back, OutReg = 0
    strict[0] = 1'b1;
    do_req(0, 1'b1, 9'd5, 4'hF, 32'hDEAD_BEEF);
    do_req(0, 1'b0, 9'd5, 4'hF, 32'h0);
    wait_drain(0);

    // Byte mask, including an all-zero mask
    do_req(0, 1'b1, 9'd7, 4'hF, 32'h1122_3344);
    do_req(0, 1'b1, 9'd7, 4'h5, 32'hAABB_CCDD);
    do_req(0, 1'b1, 9'd7, 4'h0, 32'hFFFF_FFFF);
    do_req(0, 1'b0, 9'd7, 4'hF, 32'h0);
    wait_drain(0);

    // Streaming, OutReg = 1
    strict[1] = 1'b1;
    stream_reads(1, 9'd0, 16, n);
    check("stream_fires", 32'(n), 32'd16);
    wait_drain(1);

    // Backpressure on both instances
    for (int k = 0; k < 2; k++) begin
      strict[k]    = 1'b0;
      rsp_ready[k] = 1'b0;
      stream_reads(k, 9'd0, 8, n);
      check("bp_accepted", 32'(n), (k == 0) ? 32'd3 : 32'd4);
      @(negedge clk);
      check("bp_ready_low", 32'(req_ready[k]), 32'd0);
      hold_write(k, 9'd20, 4, n);
      check("bp_write_stall", 32'(n), 32'd0);
      rsp_ready[k] = 1'b1;
      @(negedge clk);
      check("rdy_pre_pop", 32'(req_ready[k]), 32'd0);
      @(negedge clk);
      check("rdy_post_pop", 32'(req_ready[k]), 32'd1);
      wait_drain(k);
    end

    // Simultaneous push and pop with one entry buffered
    rsp_ready[0] = 1'b0;
    stream_reads(0, 9'd9, 2, n);
    check("pp_fires", 32'(n), 32'd2);
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    check("pp_count_a", 32'(u_dut0.fifo_count_q), 32'd1);
    @(negedge clk);
    check("pp_count_b", 32'(u_dut0.fifo_count_q), 32'd1);
    check("pp_valid", 32'(rsp_valid[0]), 32'd1);
    wait_drain(0);

    // Reset with two reads in flight and one buffered, OutReg = 1
    strict[1]    = 1'b0;
    rsp_ready[1] = 1'b0;
    stream_reads(1, 9'd10, 3, n);
    check("mr_fires", 32'(n), 32'd3);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp0.delete();
    exp1.delete();
    rsp_ready[1] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("mr_valid_low", 32'(rsp_valid[1]), 32'd0);
    end
    @(posedge clk);
    #1;
    strict[1] = 1'b1;
    do_req(1, 1'b0, 9'd11, 4'hF, 32'h0);
    wait_drain(1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  // Global guard so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
